// File: rtl/branch_resolver_if.sv
//------------------------------------------------------------------------------
// branch_resolver_if : EX-side branch bus, fetch redirect handshake and counters
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface branch_resolver_if #(
  parameter int PC_WIDTH      = 32,
  parameter int COUNTER_WIDTH = 32
);
  logic                     i_valid;
  logic                     o_ready;
  logic                     i_isJump;
  logic [2:0]               i_funct3;
  logic                     i_isEqual;
  logic                     i_isLessSigned;
  logic                     i_isLessUnsigned;
  logic [PC_WIDTH-1:0]      i_pc;
  logic [PC_WIDTH-1:0]      i_target;
  logic [PC_WIDTH-1:0]      i_predPC;
  logic                     o_redirectValid;
  logic                     i_redirectReady;
  logic [PC_WIDTH-1:0]      o_redirectPC;
  logic                     o_flush;
  logic                     o_resolved;
  logic                     o_taken;
  logic                     o_illegal;
  logic [COUNTER_WIDTH-1:0] o_branchCount;
  logic [COUNTER_WIDTH-1:0] o_mispredCount;

  modport master (
    output i_valid, i_isJump, i_funct3, i_isEqual, i_isLessSigned,
           i_isLessUnsigned, i_pc, i_target, i_predPC, i_redirectReady,
    input  o_ready, o_redirectValid, o_redirectPC, o_flush, o_resolved,
           o_taken, o_illegal, o_branchCount, o_mispredCount
  );

  modport slave (
    input  i_valid, i_isJump, i_funct3, i_isEqual, i_isLessSigned,
           i_isLessUnsigned, i_pc, i_target, i_predPC, i_redirectReady,
    output o_ready, o_redirectValid, o_redirectPC, o_flush, o_resolved,
           o_taken, o_illegal, o_branchCount, o_mispredCount
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolver.sv
//------------------------------------------------------------------------------
// branch_resolver : resolves EX-stage branches/jumps, detects mispredicts,
//                   pulses flush and holds a redirect request to fetch
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_resolver #(
  parameter int PC_WIDTH      = 32,
  parameter int COUNTER_WIDTH = 32
) (
  input  wire logic         i_clock,
  input  wire logic         i_reset,
  branch_resolver_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_stateNext;

  logic                     w_accept;
  logic                     w_illegal;
  logic                     w_cond;
  logic                     w_taken;
  logic [PC_WIDTH-1:0]      w_nextPC;
  logic                     w_mispred;
  logic                     w_legalAccept;

  logic                     r_flush;
  logic                     r_resolved;
  logic                     r_taken;
  logic                     r_illegal;
  logic [PC_WIDTH-1:0]      r_redirectPC;
  logic [COUNTER_WIDTH-1:0] r_branchCount;
  logic [COUNTER_WIDTH-1:0] r_mispredCount;

  assign w_accept      = bus.i_valid && (r_state == IDLE);
  assign w_illegal     = !bus.i_isJump && (bus.i_funct3[2:1] == 2'b01);
  assign w_legalAccept = w_accept && !w_illegal;

  always_comb begin
    w_cond = 1'b0;
    case (bus.i_funct3)
      3'b000:  w_cond = bus.i_isEqual;
      3'b001:  w_cond = !bus.i_isEqual;
      3'b100:  w_cond = bus.i_isLessSigned;
      3'b101:  w_cond = !bus.i_isLessSigned;
      3'b110:  w_cond = bus.i_isLessUnsigned;
      3'b111:  w_cond = !bus.i_isLessUnsigned;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken   = bus.i_isJump || w_cond;
  // Fall-through address wraps silently at the top of the address space
  assign w_nextPC  = w_taken ? bus.i_target : bus.i_pc + PC_WIDTH'(4);
  assign w_mispred = (w_nextPC != bus.i_predPC);

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:     if (w_legalAccept && w_mispred) w_stateNext = REDIRECT;
      REDIRECT: if (bus.i_redirectReady)        w_stateNext = IDLE;
      default:  w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= IDLE;
      r_flush        <= 1'b0;
      r_resolved     <= 1'b0;
      r_taken        <= 1'b0;
      r_illegal      <= 1'b0;
      r_redirectPC   <= '0;
      r_branchCount  <= '0;
      r_mispredCount <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_flush    <= w_legalAccept && w_mispred;
      r_resolved <= w_legalAccept;
      r_illegal  <= w_accept && w_illegal;
      if (w_legalAccept) begin
        r_taken <= w_taken;
      end
      if (w_legalAccept && w_mispred) begin
        r_redirectPC <= w_nextPC;
      end
      // Each counter saturates independently of the other
      if (w_legalAccept && (r_branchCount != '1)) begin
        r_branchCount <= r_branchCount + COUNTER_WIDTH'(1);
      end
      if (w_legalAccept && w_mispred && (r_mispredCount != '1)) begin
        r_mispredCount <= r_mispredCount + COUNTER_WIDTH'(1);
      end
    end
  end

  assign bus.o_ready         = (r_state == IDLE);
  assign bus.o_redirectValid = (r_state == REDIRECT);
  assign bus.o_redirectPC    = r_redirectPC;
  assign bus.o_flush         = r_flush;
  assign bus.o_resolved      = r_resolved;
  assign bus.o_taken         = r_taken;
  assign bus.o_illegal       = r_illegal;
  assign bus.o_branchCount   = r_branchCount;
  assign bus.o_mispredCount  = r_mispredCount;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
//------------------------------------------------------------------------------
// tb_branch_resolver : scoreboard bench driving operand-level branch stimulus
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_resolver;

  localparam int CW = 4;

  logic clk;
  logic rst_n;

  branch_resolver_if #(.PC_WIDTH(32), .COUNTER_WIDTH(CW)) bus();

  branch_resolver #(.PC_WIDTH(32), .COUNTER_WIDTH(CW)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          illegal;
    logic          taken;
    logic          mis;
    logic [31:0]   npc;
    logic [CW-1:0] bc;
    logic [CW-1:0] mc;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] m_bc = '0;
  logic [CW-1:0] m_mc = '0;
  bit            rr_rand = 1'b0;
  logic          prv_rv = 1'b0;
  logic          prv_rr = 1'b0;
  logic [31:0]   prv_pc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: branch semantics from the real operand values
  function automatic logic [33:0] ref_resolve(input logic jump, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] pc, input logic [31:0] tgt);
    logic ill;
    logic tk;
    logic [31:0] npc;
    ill = !jump && (f3 == 3'd2 || f3 == 3'd3);
    case (f3)
      3'd0:    tk = (a == b);
      3'd1:    tk = (a != b);
      3'd4:    tk = ($signed(a) <  $signed(b));
      3'd5:    tk = ($signed(a) >= $signed(b));
      3'd6:    tk = (a <  b);
      3'd7:    tk = (a >= b);
      default: tk = 1'b0;
    endcase
    if (jump) tk = 1'b1;
    npc = tk ? tgt : pc + 32'd4;
    return {ill, tk, npc};
  endfunction

  task automatic drive_fields(input logic jump, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] pc,
                              input logic [31:0] tgt, input logic [31:0] pred);
    bus.i_isJump         = jump;
    bus.i_funct3         = f3;
    bus.i_isEqual        = (a == b);
    bus.i_isLessSigned   = ($signed(a) < $signed(b));
    bus.i_isLessUnsigned = (a < b);
    bus.i_pc             = pc;
    bus.i_target         = tgt;
    bus.i_predPC         = pred;
  endtask

  // Runs in the phase just after a rising edge; returns one edge after acceptance
  task automatic issue(input logic jump, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic [31:0] pred);
    int n;
    logic [33:0] r;
    exp_t x;
    n = 0;
    while (!bus.o_ready) begin
      bus.i_valid = 1'($urandom_range(0, 1));
      drive_fields(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, $urandom, $urandom);
      if (rr_rand) bus.i_redirectReady = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        check("ready_timeout", 32'd0, 32'd1);
        bus.i_valid = 1'b0;
        return;
      end
    end
    drive_fields(jump, f3, a, b, pc, tgt, pred);
    bus.i_valid = 1'b1;
    if (rr_rand) bus.i_redirectReady = 1'($urandom_range(0, 1));
    r = ref_resolve(jump, f3, a, b, pc, tgt);
    x.illegal = r[33];
    x.taken   = r[32];
    x.npc     = r[31:0];
    x.mis     = !x.illegal && (x.npc != pred);
    if (!x.illegal) begin
      if (m_bc != {CW{1'b1}}) m_bc = m_bc + 1'b1;
      if (x.mis && m_mc != {CW{1'b1}}) m_mc = m_mc + 1'b1;
    end
    x.bc = m_bc;
    x.mc = m_mc;
    q.push_back(x);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prv_rv = 1'b0;
      prv_rr = 1'b0;
    end else begin
      if (bus.o_resolved || bus.o_illegal) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("illegal", 32'(bus.o_illegal), 32'(e.illegal));
          check("resolved", 32'(bus.o_resolved), 32'(!e.illegal));
          if (!e.illegal) check("taken", 32'(bus.o_taken), 32'(e.taken));
          check("flush", 32'(bus.o_flush), 32'(e.mis));
          check("redirect_valid", 32'(bus.o_redirectValid), 32'(e.mis));
          if (e.mis) check("redirect_pc", bus.o_redirectPC, e.npc);
          check("branch_count", 32'(bus.o_branchCount), 32'(e.bc));
          check("mispred_count", 32'(bus.o_mispredCount), 32'(e.mc));
        end
      end else begin
        check("flush_without_resolve", 32'(bus.o_flush), 32'd0);
      end
      if (prv_rv && !prv_rr) begin
        check("redirect_hold", 32'(bus.o_redirectValid), 32'd1);
        check("redirect_pc_stable", bus.o_redirectPC, prv_pc);
      end else if (prv_rv && prv_rr) begin
        check("redirect_drop", 32'(bus.o_redirectValid), 32'd0);
      end
      check("ready_vs_redirect", 32'(bus.o_ready), 32'(!bus.o_redirectValid));
      prv_rv = bus.o_redirectValid;
      prv_rr = bus.i_redirectReady;
      prv_pc = bus.o_redirectPC;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] r;
    logic [31:0] a, b, pc, tgt, pred;
    logic [2:0]  f3;
    logic        jump;
    int          n;

    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_redirectReady = 1'b0;
    drive_fields(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(bus.o_ready), 32'd1);
    check("reset_redirect_valid", 32'(bus.o_redirectValid), 32'd0);
    check("reset_redirect_pc", bus.o_redirectPC, 32'd0);
    check("reset_pulses", {29'd0, bus.o_flush, bus.o_resolved, bus.o_illegal}, 32'd0);
    check("reset_taken", 32'(bus.o_taken), 32'd0);
    check("reset_counts", {bus.o_branchCount, bus.o_mispredCount}, 32'd0);
    rst_n = 1'b1;

    issue(1'b0, 3'd0, 32'd7, 32'd7, 32'h100, 32'h180, 32'h180);      // BEQ taken, correct
    issue(1'b0, 3'd6, 32'd9, 32'd3, 32'h200, 32'h280, 32'h300);      // BLTU not taken, mispredict
    bus.i_valid = 1'b1;
    drive_fields(1'b1, 3'd0, 32'd0, 32'd0, 32'h400, 32'h500, 32'h0); // ignored while redirecting
    repeat (3) begin
      check("ready_low_in_redirect", 32'(bus.o_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
    check("redirect_pc_value", bus.o_redirectPC, 32'h204);
    bus.i_redirectReady = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_redirect", 32'(bus.o_ready), 32'd1);
    bus.i_redirectReady = 1'b0;

    issue(1'b0, 3'd2, 32'd1, 32'd2, 32'h600, 32'h700, 32'h0);        // illegal funct3
    issue(1'b1, 3'd2, 32'd1, 32'd2, 32'h600, 32'h700, 32'h700);      // jump ignores funct3

    issue(1'b0, 3'd1, 32'd1, 32'd2, 32'h800, 32'h900, 32'h900);      // BNE taken
    issue(1'b0, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 32'h10, 32'h0); // BGE not taken, wraps
    issue(1'b1, 3'd0, 32'd0, 32'd0, 32'hA00, 32'hB00, 32'hB00);      // JAL
    check("ready_after_b2b", 32'(bus.o_ready), 32'd1);

    issue(1'b0, 3'd4, 32'hFFFF_FFF0, 32'd5, 32'hC00, 32'hD00, 32'hC04); // BLT taken, mispredict
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    q.delete();
    m_bc = '0;
    m_mc = '0;
    #1;
    check("async_reset_redirect", 32'(bus.o_redirectValid), 32'd0);
    check("async_reset_counts", {bus.o_branchCount, bus.o_mispredCount}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("ready_after_reset", 32'(bus.o_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      issue(1'b0, 3'd0, 32'd3, 32'd4, 32'(i * 8), 32'h0, 32'(i * 8 + 4));
    end
    bus.i_redirectReady = 1'b1;
    issue(1'b1, 3'd0, 32'd0, 32'd0, 32'h1000, 32'h2000, 32'h1004);
    check("sat_branch_count", 32'(bus.o_branchCount), 32'd15);
    check("sat_mispred_count", 32'(bus.o_mispredCount), 32'd1);

    rr_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.i_redirectReady = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      jump = ($urandom_range(0, 7) == 0);
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
      pc   = $urandom & 32'hFFFF_FFFC;
      tgt  = $urandom & 32'hFFFF_FFFC;
      r    = ref_resolve(jump, f3, a, b, pc, tgt);
      case ($urandom_range(0, 3))
        0:       pred = r[31:0];
        1:       pred = pc + 32'd4;
        2:       pred = tgt;
        default: pred = $urandom;
      endcase
      issue(jump, f3, a, b, pc, tgt, pred);
    end

    rr_rand = 1'b0;
    bus.i_redirectReady = 1'b1;
    n = 0;
    while ((q.size() != 0 || !bus.o_ready) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
